// File: rtl/raybox_reg_pkg.sv
// Shared definitions for the raybox SPI register loader and its consumers.
// Field widths, loader FSM states and named register slots.
package raybox_reg_pkg;

   localparam int CMD_W     = 4;
   localparam int DATA_W    = 16;
   localparam int WORD_BITS = CMD_W + DATA_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } loader_state_t;

   // Register slots as seen by the renderer.
   localparam int REG_SKY   = 0;
   localparam int REG_FLOOR = 1;
   localparam int REG_LEAK  = 2;

endpackage

// File: rtl/input_sync.sv
// Parameterised-width two-flop synchronizer with a per-bit reset value,
// used to bring asynchronous pad signals into the system clock domain.
module input_sync #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] s1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         s1  <= RESET_VAL;
         o_q <= RESET_VAL;
      end else begin
         s1  <= i_d;
         o_q <= s1;
      end
   end

endmodule

// File: rtl/spi_reg_loader.sv
// Oversampled SPI (mode 0, MSB first) register loader: decodes cmd+data words
// into shadow registers and commits pending ones to live outputs on a frame strobe.
module spi_reg_loader
   import raybox_reg_pkg::*;
#(
   parameter int REG_COUNT = 8,
   parameter int CMD_W     = raybox_reg_pkg::CMD_W,
   parameter int DATA_W    = raybox_reg_pkg::DATA_W
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic                        i_reg_csb,
   input  logic                        i_reg_sclk,
   input  logic                        i_reg_mosi,
   input  logic                        i_commit,
   output logic [REG_COUNT*DATA_W-1:0] o_regs,
   output logic [REG_COUNT-1:0]        o_pending,
   output logic                        o_word_strobe,
   output logic                        o_bad_cmd,
   output logic                        o_busy
);

   localparam int WORD_BITS = CMD_W + DATA_W;
   localparam int CNT_W     = $clog2(WORD_BITS + 1);

   logic [2:0]           sync_q;
   logic                 csb_s;
   logic                 sclk_s;
   logic                 mosi_s;
   logic                 sclk_s3;
   logic                 rise;

   loader_state_t        state;
   logic [CNT_W-1:0]     bit_cnt;
   logic [WORD_BITS-1:0] shift_reg;
   logic                 land;
   logic                 busy;

   logic [CMD_W-1:0]     cmd_f;
   logic [DATA_W-1:0]    data_f;
   logic                 cmd_ok;

   logic [DATA_W-1:0]    shadow [REG_COUNT];
   logic [DATA_W-1:0]    live   [REG_COUNT];
   logic [REG_COUNT-1:0] pending;
   logic                 strobe;
   logic                 bad;

   // Idle pad levels: csb deasserted, sclk low, mosi low.
   input_sync #(
      .WIDTH     (3),
      .RESET_VAL (3'b100)
   ) u_sync (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     ({i_reg_csb, i_reg_sclk, i_reg_mosi}),
      .o_q     (sync_q)
   );

   assign csb_s  = sync_q[2];
   assign sclk_s = sync_q[1];
   assign mosi_s = sync_q[0];
   assign rise   = sclk_s & ~sclk_s3;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         sclk_s3 <= 1'b0;
      end else begin
         sclk_s3 <= sclk_s;
      end
   end

   // Word framing. 'land' marks the single cycle after the last bit arrives.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state     <= IDLE;
         bit_cnt   <= '0;
         shift_reg <= '0;
         land      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         land <= 1'b0;
         case (state)
            IDLE: begin
               if (!csb_s) begin
                  bit_cnt <= '0;
                  state   <= SHIFT;
                  busy    <= 1'b1;
               end
            end
            SHIFT: begin
               if (csb_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (rise) begin
                  shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_s};
                  bit_cnt   <= bit_cnt + 1'b1;
                  if (bit_cnt == CNT_W'(WORD_BITS - 1)) begin
                     state <= DONE;
                     land  <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (csb_s) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign cmd_f  = shift_reg[WORD_BITS-1 -: CMD_W];
   assign data_f = shift_reg[DATA_W-1:0];
   assign cmd_ok = (int'(cmd_f) < REG_COUNT);

   // Commit reads pre-write shadow/pending; a same-cycle landing word stays pending.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < REG_COUNT; k++) begin
            shadow[k] <= '0;
            live[k]   <= '0;
         end
         pending <= '0;
         strobe  <= 1'b0;
         bad     <= 1'b0;
      end else begin
         strobe <= 1'b0;
         bad    <= 1'b0;
         if (i_commit) begin
            for (int k = 0; k < REG_COUNT; k++) begin
               if (pending[k]) begin
                  live[k]    <= shadow[k];
                  pending[k] <= 1'b0;
               end
            end
         end
         if (land) begin
            if (cmd_ok) begin
               for (int k = 0; k < REG_COUNT; k++) begin
                  if (int'(cmd_f) == k) begin
                     shadow[k]  <= data_f;
                     pending[k] <= 1'b1;
                  end
               end
               strobe <= 1'b1;
            end else begin
               bad <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      o_regs = '0;
      for (int k = 0; k < REG_COUNT; k++) begin
         o_regs[k*DATA_W +: DATA_W] = live[k];
      end
   end

   assign o_pending     = pending;
   assign o_word_strobe = strobe;
   assign o_bad_cmd     = bad;
   assign o_busy        = busy;

endmodule
